// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment message scroller slice.
package seg7_pkg;
  localparam int unsigned DIGITS   = 4;
  localparam int unsigned NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] BLANK_CODE_DEF = 4'hF;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SCROLL = 2'd2
  } state_e;
endpackage

// File: rtl/seg7_msg_scroller_if.sv
// Nibble write port (valid/ready with end-of-message marker) into the scroller.
interface seg7_msg_scroller_if;
  import seg7_pkg::*;
  logic                wr_valid;
  logic                wr_ready;
  logic [NIBBLE_W-1:0] wr_data;
  logic                wr_last;

  modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);
endinterface

// File: rtl/seg7_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled, tick_o high on the terminal count.
module seg7_tick_gen #(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && !clr_i && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seg7_msg_scroller.sv
// Stores a hex message and scrolls a 4-digit window across it circularly.
// Optional SCROLL_PAUSE_AT_END_EN: hold the message start for PAUSE_STEPS extra periods.
module seg7_msg_scroller
  import seg7_pkg::*;
#(
  parameter int unsigned         MSG_DEPTH  = 16,
  parameter int unsigned         SCROLL_DIV = 50_000_000,
  parameter logic [NIBBLE_W-1:0] BLANK_CODE = BLANK_CODE_DEF
`ifdef SCROLL_PAUSE_AT_END_EN
  , parameter int unsigned       PAUSE_STEPS = 3
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  seg7_msg_scroller_if.slave            wr,
  input  logic                          msg_clr,
  input  logic                          scroll_en,
  output logic [DIGITS*NIBBLE_W-1:0]    win_data,
  output logic                          win_valid,
  output logic [$clog2(MSG_DEPTH):0]    msg_len,
  output logic                          scrolling
);
  localparam int unsigned AW = $clog2(MSG_DEPTH);
  localparam int unsigned LW = AW + 1;

  state_e                     state_q, state_d;
  logic [LW-1:0]              len_q, len_d;
  logic [AW-1:0]              head_q, head_d;
  logic [DIGITS*NIBBLE_W-1:0] win_q, win_d;
  logic                       vld_q, vld_d;
  logic                       refresh_q, refresh_d;
  logic [NIBBLE_W-1:0]        mem_q [MSG_DEPTH];
  logic [DIGITS*NIBBLE_W-1:0] taps;
  logic [LW-1:0]              head_inc;
  logic [AW-1:0]              head_next;
  logic                       wr_fire, tick;
`ifdef SCROLL_PAUSE_AT_END_EN
  localparam int unsigned PW = $clog2(PAUSE_STEPS + 1);
  logic [PW-1:0]              pause_q, pause_d;
`endif

  assign wr.wr_ready = (state_q != ST_SCROLL);
  assign wr_fire     = wr.wr_valid && wr.wr_ready && !msg_clr;

  seg7_tick_gen #(.DIV(SCROLL_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en_i   (scroll_en && (state_q == ST_SCROLL)),
    .clr_i  (msg_clr || (state_q != ST_SCROLL)),
    .tick_o (tick)
  );

  assign head_inc  = {1'b0, head_q} + LW'(1);
  assign head_next = (head_inc == len_q) ? '0 : head_inc[AW-1:0];

  // Wrap by repeated conditional subtract; short messages may wrap several times.
  always_comb begin
    logic [LW:0] idx;
    taps = '0;
    for (int k = 0; k < DIGITS; k++) begin
      idx = {2'b00, head_q} + (LW+1)'(k);
      for (int j = 0; j < DIGITS; j++)
        if (idx >= {1'b0, len_q}) idx = idx - {1'b0, len_q};
      taps[(DIGITS-1-k)*NIBBLE_W +: NIBBLE_W] = mem_q[idx[AW-1:0]];
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    head_d    = head_q;
    win_d     = win_q;
    vld_d     = 1'b0;
    refresh_d = 1'b0;
`ifdef SCROLL_PAUSE_AT_END_EN
    pause_d   = pause_q;
`endif
    if (msg_clr) begin
      state_d = ST_EMPTY;
      len_d   = '0;
      head_d  = '0;
      win_d   = {DIGITS{BLANK_CODE}};
      vld_d   = (state_q == ST_SCROLL);
`ifdef SCROLL_PAUSE_AT_END_EN
      pause_d = '0;
`endif
    end else begin
      case (state_q)
        ST_EMPTY, ST_LOAD: if (wr_fire) begin
          len_d = len_q + LW'(1);
          if (wr.wr_last || (len_q == LW'(MSG_DEPTH - 1))) begin
            state_d   = ST_SCROLL;
            head_d    = '0;
            refresh_d = 1'b1;
`ifdef SCROLL_PAUSE_AT_END_EN
            pause_d   = '0;
`endif
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_SCROLL: begin
          if (refresh_q) begin
            win_d = taps;
            vld_d = 1'b1;
          end
          if (tick) begin
`ifdef SCROLL_PAUSE_AT_END_EN
            if (pause_q != '0) begin
              pause_d = pause_q - PW'(1);
            end else begin
              head_d    = head_next;
              refresh_d = 1'b1;
              if (head_next == '0) pause_d = PW'(PAUSE_STEPS);
            end
`else
            head_d    = head_next;
            refresh_d = 1'b1;
`endif
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      len_q     <= '0;
      head_q    <= '0;
      win_q     <= {DIGITS{BLANK_CODE}};
      vld_q     <= 1'b0;
      refresh_q <= 1'b0;
`ifdef SCROLL_PAUSE_AT_END_EN
      pause_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      head_q    <= head_d;
      win_q     <= win_d;
      vld_q     <= vld_d;
      refresh_q <= refresh_d;
`ifdef SCROLL_PAUSE_AT_END_EN
      pause_q   <= pause_d;
`endif
    end
  end

  // Message storage is not reset; only len_q says what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[len_q[AW-1:0]] <= wr.wr_data;
  end

  assign win_data  = win_q;
  assign win_valid = vld_q;
  assign msg_len   = len_q;
  assign scrolling = (state_q == ST_SCROLL);
endmodule

// File: tb/tb_seg7_msg_scroller.sv
// Directed bench for seg7_msg_scroller with SCROLL_DIV=4, MSG_DEPTH=8.
module tb_seg7_msg_scroller;
  logic        clk = 1'b0;
  logic        reset, msg_clr, scroll_en;
  logic [15:0] win_data;
  logic        win_valid, scrolling;
  logic [3:0]  msg_len;
  int          checks = 0;
  int          errors = 0;
  logic        seen_vld, win_moved;
  logic [15:0] win_hold;

  seg7_msg_scroller_if wr_if ();

  seg7_msg_scroller #(
    .MSG_DEPTH  (8),
    .SCROLL_DIV (4)
`ifdef SCROLL_PAUSE_AT_END_EN
    , .PAUSE_STEPS (2)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr_if.slave),
    .msg_clr   (msg_clr),
    .scroll_en (scroll_en),
    .win_data  (win_data),
    .win_valid (win_valid),
    .msg_len   (msg_len),
    .scrolling (scrolling)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [3:0] d, input logic last);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    wr_if.wr_last  = last;
    tick();
    wr_if.wr_valid = 1'b0;
    wr_if.wr_last  = 1'b0;
  endtask

  task automatic clear();
    msg_clr = 1'b1;
    tick();
    msg_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; msg_clr = 1'b0; scroll_en = 1'b1;
    wr_if.wr_valid = 1'b0; wr_if.wr_data = 4'h0; wr_if.wr_last = 1'b0;
    ticks(2);
    chk("rst_win",   32'(win_data),  32'hFFFF);
    chk("rst_ready", 32'(wr_if.wr_ready), 32'd1);
    chk("rst_len",   32'(msg_len),   32'd0);
    chk("rst_scr",   32'(scrolling), 32'd0);
    chk("rst_vld",   32'(win_valid), 32'd0);
    reset = 1'b0;
    tick();

    // 5-nibble message; last beat accepted at edge E
    beat(4'h1, 0); beat(4'h4, 0); beat(4'h3, 0); beat(4'h5, 0); beat(4'hA, 1);
    chk("m5_scr",   32'(scrolling),       32'd1);
    chk("m5_len",   32'(msg_len),         32'd5);
    chk("m5_ready", 32'(wr_if.wr_ready),  32'd0);
    tick();                                               // E+1
    chk("m5_win0",  32'(win_data),  32'h1435);
    chk("m5_vld0",  32'(win_valid), 32'd1);
    tick();                                               // E+2
    chk("m5_vld0_off", 32'(win_valid), 32'd0);
    ticks(2);                                             // E+4
    chk("m5_hold4", 32'(win_data), 32'h1435);
    tick();                                               // E+5
    chk("m5_win1",  32'(win_data),  32'h435A);
    chk("m5_vld1",  32'(win_valid), 32'd1);
    ticks(4);                                             // E+9
    chk("m5_win2",  32'(win_data),  32'h35A1);
    ticks(12);                                            // E+21
    chk("m5_wrap",  32'(win_data),  32'h1435);

    // freeze 20 clks; writes during SCROLL must be ignored
    scroll_en = 1'b0;
    seen_vld = 1'b0; win_moved = 1'b0; win_hold = win_data;
    wr_if.wr_valid = 1'b1; wr_if.wr_data = 4'h7;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (win_valid) seen_vld = 1'b1;
      if (win_data !== win_hold) win_moved = 1'b1;
    end
    wr_if.wr_valid = 1'b0;
    chk("frz_vld",  32'(seen_vld),  32'd0);
    chk("frz_win",  32'(win_moved), 32'd0);
    chk("frz_len",  32'(msg_len),   32'd5);
    scroll_en = 1'b1;
    ticks(3);                                             // E+44
    chk("res_hold", 32'(win_data), 32'h1435);
    tick();                                               // E+45
    chk("res_step", 32'(win_data), 32'h435A);

    // msg_clr coincident with the step tick at E+48
    ticks(2);
    clear();
    chk("clr_scr",   32'(scrolling),      32'd0);
    chk("clr_win",   32'(win_data),       32'hFFFF);
    chk("clr_vld",   32'(win_valid),      32'd1);
    chk("clr_len",   32'(msg_len),        32'd0);
    chk("clr_ready", 32'(wr_if.wr_ready), 32'd1);
    tick();
    chk("clr_vld1",  32'(win_valid), 32'd0);
    clear();
    chk("clr_empty_vld", 32'(win_valid), 32'd0);

    // full buffer, implicit last
    for (int i = 0; i < 8; i++) beat(4'(i), 0);
    chk("full_scr",   32'(scrolling),      32'd1);
    chk("full_ready", 32'(wr_if.wr_ready), 32'd0);
    chk("full_len",   32'(msg_len),        32'd8);
    tick();
    chk("full_win",   32'(win_data), 32'h0123);

    // two-nibble message repeats in the window
    clear();
    beat(4'hC, 0); beat(4'hD, 1);
    tick();
    chk("m2_win0", 32'(win_data), 32'hCDCD);
    chk("m2_len",  32'(msg_len),  32'd2);
    ticks(4);
    chk("m2_win1", 32'(win_data), 32'hDCDC);

    // reset mid-LOAD discards the partial message
    clear();
    beat(4'h2, 0); beat(4'h6, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rl_len", 32'(msg_len),   32'd0);
    chk("rl_scr", 32'(scrolling), 32'd0);
    beat(4'h9, 1);
    tick();
    chk("m1_win", 32'(win_data), 32'h9999);

`ifdef SCROLL_PAUSE_AT_END_EN
    clear();
    beat(4'h1, 0); beat(4'h4, 0); beat(4'h3, 0); beat(4'h5, 0); beat(4'hA, 1);
    ticks(32);
    chk("pause_hold", 32'(win_data), 32'h1435);
    tick();
    chk("pause_step", 32'(win_data), 32'h435A);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
